// File: rtl/instr_sequencer.sv
`timescale 1ns/1ps
// Multi-cycle control FSM for the piRISC RV32I core: fetch handshake, opcode
// decode, execute, optional data-memory access and commit with retire count.
module instr_sequencer #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic              comparator,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  output logic              ir_en,
  output logic              alu_src,
  output logic              alu_pc,
  output logic [1:0]        wb_select,
  output logic              rf_we,
  output logic              pc_en,
  output logic [1:0]        pc_select,
  output logic              illegal,
  output logic [DWIDTH-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_COMMIT, S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD
  } class_e;

  function automatic class_e classify(input logic [6:0] op);
    case (op)
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1100011: return C_BRANCH;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      default:    return C_BAD;
    endcase
  endfunction

  function automatic logic uses_imm_f(input class_e c);
    return (c == C_I) || (c == C_LOAD) || (c == C_STORE) || (c == C_JALR) || (c == C_AUIPC);
  endfunction

  function automatic logic writes_rd_f(input class_e c);
    return !((c == C_STORE) || (c == C_BRANCH));
  endfunction

  function automatic logic [1:0] pc_sel_f(input class_e c, input logic tk);
    case (c)
      C_BRANCH: return tk ? 2'b01 : 2'b00;
      C_JAL:    return 2'b10;
      C_JALR:   return 2'b11;
      default:  return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] wb_sel_f(input class_e c);
    case (c)
      C_LOAD:        return 2'b01;
      C_JAL, C_JALR: return 2'b10;
      C_LUI:         return 2'b11;
      default:       return 2'b00;
    endcase
  endfunction

  state_e              state_q;
  class_e              cls_q;
  class_e              cls_d;
  logic [6:0]          opcode_q;
  logic                rd_nz_q;
  logic                taken_q;
  logic                imem_req_q, dmem_req_q, dmem_we_q;
  logic                alu_src_q, alu_pc_q, rf_we_q, pc_en_q, illegal_q;
  logic [1:0]          wb_select_q, pc_select_q;
  logic [DWIDTH-1:0]   instret_q;
  logic                is_mem;
  logic                go_commit_d;
  logic                commit_tk_d;
  logic                unused_instr_hi;

  assign cls_d  = classify(opcode_q);
  assign is_mem = (cls_q == C_LOAD) || (cls_q == C_STORE);
  // Branch outcome is taken straight from the comparator when EXECUTE commits directly.
  assign commit_tk_d = (state_q == S_EXECUTE) ? comparator : taken_q;
  assign go_commit_d = ((state_q == S_EXECUTE) && !is_mem) ||
                       ((state_q == S_MEMORY) && dmem_ack);
  assign unused_instr_hi = ^instr[31:12];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      cls_q       <= C_R;
      opcode_q    <= 7'd0;
      rd_nz_q     <= 1'b0;
      taken_q     <= 1'b0;
      imem_req_q  <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      alu_src_q   <= 1'b0;
      alu_pc_q    <= 1'b0;
      rf_we_q     <= 1'b0;
      pc_en_q     <= 1'b0;
      illegal_q   <= 1'b0;
      wb_select_q <= 2'b00;
      pc_select_q <= 2'b00;
      instret_q   <= '0;
    end else begin
      imem_req_q  <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      alu_src_q   <= 1'b0;
      alu_pc_q    <= 1'b0;
      rf_we_q     <= 1'b0;
      pc_en_q     <= 1'b0;
      wb_select_q <= 2'b00;
      pc_select_q <= 2'b00;
      case (state_q)
        S_FETCH: begin
          if (imem_req_q && imem_ack) begin
            opcode_q <= instr[6:0];
            rd_nz_q  <= |instr[11:7];
            state_q  <= S_DECODE;
          end else begin
            imem_req_q <= 1'b1;
          end
        end
        S_DECODE: begin
          cls_q <= cls_d;
          if (cls_d == C_BAD) begin
            illegal_q <= 1'b1;
            state_q   <= S_TRAP;
          end else begin
            alu_src_q <= uses_imm_f(cls_d);
            alu_pc_q  <= (cls_d == C_AUIPC);
            state_q   <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (cls_q == C_BRANCH) taken_q <= comparator;
          if (is_mem) begin
            dmem_req_q <= 1'b1;
            dmem_we_q  <= (cls_q == C_STORE);
            alu_src_q  <= 1'b1;
            state_q    <= S_MEMORY;
          end else begin
            state_q <= S_COMMIT;
          end
        end
        S_MEMORY: begin
          if (dmem_ack) begin
            state_q <= S_COMMIT;
          end else begin
            dmem_req_q <= 1'b1;
            dmem_we_q  <= (cls_q == C_STORE);
            alu_src_q  <= 1'b1;
          end
        end
        S_COMMIT: begin
          imem_req_q <= 1'b1;
          state_q    <= S_FETCH;
        end
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_FETCH;
      endcase
      if (go_commit_d) begin
        pc_en_q     <= 1'b1;
        pc_select_q <= pc_sel_f(cls_q, commit_tk_d);
        rf_we_q     <= writes_rd_f(cls_q) && rd_nz_q;
        wb_select_q <= wb_sel_f(cls_q);
        instret_q   <= instret_q + DWIDTH'(1);
      end
    end
  end

  assign imem_req  = imem_req_q;
  assign ir_en     = imem_req_q && imem_ack;
  assign dmem_req  = dmem_req_q;
  assign dmem_we   = dmem_we_q;
  assign alu_src   = alu_src_q;
  assign alu_pc    = alu_pc_q;
  assign wb_select = wb_select_q;
  assign rf_we     = rf_we_q;
  assign pc_en     = pc_en_q;
  assign pc_select = pc_select_q;
  assign illegal   = illegal_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_instr_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for instr_sequencer: per-instruction expected output
// timeline derived from the opcode rules, compared every cycle.
module tb_instr_sequencer;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   instr;
  logic          imem_req, imem_ack, comparator, dmem_req, dmem_we, dmem_ack;
  logic          ir_en, alu_src, alu_pc, rf_we, pc_en, illegal;
  logic [1:0]    wb_select, pc_select;
  logic [DW-1:0] instret;

  always #5 clk = ~clk;

  instr_sequencer #(.DWIDTH(DW)) dut (
    .clk(clk), .reset(reset), .instr(instr), .imem_req(imem_req), .imem_ack(imem_ack),
    .comparator(comparator), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .ir_en(ir_en), .alu_src(alu_src), .alu_pc(alu_pc), .wb_select(wb_select), .rf_we(rf_we),
    .pc_en(pc_en), .pc_select(pc_select), .illegal(illegal), .instret(instret)
  );

  // Expected outputs for the current cycle
  logic          e_imem_req, e_ir_en, e_dmem_req, e_dmem_we, e_alu_src, e_alu_pc;
  logic          e_rf_we, e_pc_en, e_illegal;
  logic [1:0]    e_wb_select, e_pc_select;
  logic [DW-1:0] e_instret;
  logic [DW-1:0] count;
  bit            chk_en = 1'b0;

  int n_cmp = 0, n_mis = 0;
  int cyc = 0, req_rise_cyc = 0, pc_en_cyc = 0, pc_en_cnt = 0, dmem_cyc_cnt = 0;
  logic prev_req = 1'b0;

  string  lit_nm [8];
  longint lit_a  [8];
  longint lit_e  [8];
  int     lit_seq = 0, lit_done = 0;

  logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

  always @(negedge clk) begin : compare
    logic [12:0] act, expv;
    cyc++;
    if (chk_en) begin
      act  = {imem_req, ir_en, dmem_req, dmem_we, alu_src, alu_pc, wb_select, rf_we,
              pc_en, pc_select, illegal};
      expv = {e_imem_req, e_ir_en, e_dmem_req, e_dmem_we, e_alu_src, e_alu_pc, e_wb_select,
              e_rf_we, e_pc_en, e_pc_select, e_illegal};
      n_cmp++;
      if (act !== expv || instret !== e_instret) begin
        n_mis++;
        $display("FAIL cycle%0d outputs {imem_req,ir_en,dmem_req,dmem_we,alu_src,alu_pc,wb_sel,rf_we,pc_en,pc_sel,illegal}: got %b instret=%0d, expected %b instret=%0d",
                 cyc, act, instret, expv, e_instret);
      end
    end
    while (lit_done != lit_seq) begin
      int k;
      k = lit_done % 8;
      n_cmp++;
      if (lit_a[k] != lit_e[k]) begin
        n_mis++;
        $display("FAIL %s: got %0d, expected %0d", lit_nm[k], lit_a[k], lit_e[k]);
      end
      lit_done++;
    end
    if (imem_req && !prev_req) req_rise_cyc = cyc;
    prev_req = imem_req;
    if (pc_en) begin
      pc_en_cyc = cyc;
      pc_en_cnt++;
    end
    if (dmem_req) dmem_cyc_cnt++;
  end

  task automatic check_lit(input string nm, input longint a, input longint e);
    lit_nm[lit_seq % 8] = nm;
    lit_a[lit_seq % 8]  = a;
    lit_e[lit_seq % 8]  = e;
    lit_seq++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_exp();
    e_imem_req = 0; e_ir_en = 0; e_dmem_req = 0; e_dmem_we = 0; e_alu_src = 0; e_alu_pc = 0;
    e_rf_we = 0; e_pc_en = 0; e_illegal = 0; e_wb_select = 0; e_pc_select = 0;
    e_instret = count;
  endtask

  task automatic noise(input bit i, input bit d, input bit c);
    if (i) imem_ack   = ($urandom_range(0, 1) == 1);
    if (d) dmem_ack   = ($urandom_range(0, 1) == 1);
    if (c) comparator = ($urandom_range(0, 1) == 1);
  endtask

  task automatic release_reset();
    reset = 1'b1;
    clr_exp();
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    step();
  endtask

  task automatic idle_fetch(input int n);
    for (int i = 0; i < n; i++) begin
      clr_exp(); e_imem_req = 1; imem_ack = 0; noise(0, 1, 1); step();
    end
  endtask

  // One instruction: fw fetch wait cycles, mw memory wait cycles, optional reset during MEMORY.
  task automatic run_instr(input logic [31:0] iw, input int fw, input int mw, input logic cmp,
                           input int abort_at);
    logic [6:0] op;
    bit         legal, imm, mem, st, rdnz, wr;
    logic [1:0] psel, wb;
    op    = iw[6:0];
    rdnz  = (iw[11:7] != 5'd0);
    legal = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    imm   = op inside {7'h13, 7'h03, 7'h23, 7'h67, 7'h17};
    mem   = op inside {7'h03, 7'h23};
    st    = (op == 7'h23);
    psel  = (op == 7'h63) ? (cmp ? 2'd1 : 2'd0) : (op == 7'h6F) ? 2'd2 : (op == 7'h67) ? 2'd3 : 2'd0;
    wr    = !(op == 7'h23 || op == 7'h63);
    wb    = (op == 7'h03) ? 2'd1 : (op == 7'h6F || op == 7'h67) ? 2'd2 : (op == 7'h37) ? 2'd3 : 2'd0;
    for (int i = 0; i < fw; i++) begin
      clr_exp(); e_imem_req = 1; imem_ack = 0; instr = $urandom; noise(0, 1, 1); step();
    end
    clr_exp(); e_imem_req = 1; e_ir_en = 1; imem_ack = 1; instr = iw; noise(0, 1, 1); step();
    clr_exp(); instr = $urandom; noise(1, 1, 1); step();
    if (!legal) return;
    clr_exp(); e_alu_src = imm; e_alu_pc = (op == 7'h17); noise(1, 1, 0); comparator = cmp; step();
    if (mem) begin
      for (int i = 0; i <= mw; i++) begin
        clr_exp(); e_dmem_req = 1; e_dmem_we = st; e_alu_src = 1; noise(1, 0, 1);
        dmem_ack = (i == mw);
        if (i == abort_at) begin
          dmem_ack = 1'b0;
          #2;
          reset = 1'b0;
          count = '0;
          clr_exp();
          #1;
          check_lit("async_dmem_req_drop", dmem_req, 0);
          step();
          return;
        end
        step();
      end
    end
    count = count + 1'b1;
    clr_exp(); e_pc_en = 1; e_pc_select = psel; e_rf_we = wr && rdnz; e_wb_select = wb;
    noise(1, 1, 1); step();
  endtask

  initial begin
    int d0, p0;
    logic [31:0] iw;
    instr = '0; imem_ack = 0; dmem_ack = 0; comparator = 0; reset = 1'b0; count = '0;
    clr_exp();
    chk_en = 1'b1;
    step(); step();
    check_lit("reset_instret", instret, 0);
    check_lit("reset_imem_req", imem_req, 0);
    release_reset();

    run_instr(32'h00500093, 0, 0, 1'b0, -1);
    check_lit("addi_latency", pc_en_cyc - req_rise_cyc, 3);
    check_lit("addi_instret", instret, 1);

    d0 = dmem_cyc_cnt;
    run_instr(32'h0000A103, 0, 3, 1'b0, -1);
    check_lit("lw_latency", pc_en_cyc - req_rise_cyc, 7);
    check_lit("lw_dmem_req_cycles", dmem_cyc_cnt - d0, 4);

    run_instr(32'h00208463, 1, 0, 1'b1, -1);
    run_instr(32'h00208463, 0, 0, 1'b0, -1);
    run_instr(32'h0080006F, 0, 0, 1'b0, -1);
    run_instr(32'h000080E7, 2, 0, 1'b0, -1);
    check_lit("instret_after_directed", instret, 6);

    for (int n = 0; n < 80; n++) begin
      iw = $urandom;
      iw[6:0] = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 3) == 0) iw[11:7] = 5'd0;
      run_instr(iw, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 1) == 1), -1);
    end
    idle_fetch(2);

    force dut.instret_q = '1;
    count = '1;
    clr_exp(); e_imem_req = 1; imem_ack = 0;
    #1 release dut.instret_q;
    step();
    run_instr(32'h00500093, 0, 0, 1'b0, -1);
    check_lit("instret_wrap", instret, 0);

    run_instr(32'h0000A103, 0, 3, 1'b0, 1);
    clr_exp(); step();
    release_reset();
    run_instr(32'h00500093, 0, 0, 1'b0, -1);
    check_lit("instret_after_abort", instret, 1);

    p0 = pc_en_cnt;
    run_instr(32'h0000007F, 0, 0, 1'b0, -1);
    for (int i = 0; i < 20; i++) begin
      clr_exp(); e_illegal = 1; noise(1, 1, 1); step();
    end
    check_lit("trap_pc_en_pulses", pc_en_cnt - p0, 0);
    check_lit("trap_illegal", illegal, 1);
    reset = 1'b0; count = '0; clr_exp(); step(); step();
    release_reset();
    run_instr(32'h00500093, 0, 0, 1'b0, -1);
    check_lit("post_trap_instret", instret, 1);
    idle_fetch(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
